trojan_scan_ctrl: RTL
=====================

TROJAN_SCAN_CTRL -- requirements
Module: trojan_scan_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2: idle cycles between applying a vector and sampling outputs, legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: one-cycle pulse that begins a scan.
REQ-005 SHALL have port cut_a, cut_b, cut_c, outputs, 1 bit each: stimulus to the circuit under test (CUT).
REQ-006 SHALL have port cut_e, cut_f, cut_g, cut_h, inputs, 1 bit each: CUT responses.
REQ-007 SHALL have port busy, output, 1 bit: scan in progress.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when the scan completes.
REQ-009 SHALL have port mismatch_cnt, output, 4 bits: number of failing vectors (0..8).
REQ-010 SHALL have port trojan_flag, output, 1 bit: high when mismatch_cnt is non-zero after done.
REQ-011 SHALL have port fail_vec, output, 3 bits: index of the first failing vector.
REQ-012 SHALL have port fail_mask, output, 4 bits: {E,F,G,H} mismatch bits of the first failing vector.

Function
REQ-013 SHALL implement FSM states IDLE, APPLY, SETTLE, CAPTURE, DONE.
REQ-014 IDLE->APPLY on start; vector index vec cleared to 0, mismatch_cnt cleared, trojan_flag cleared.
REQ-015 APPLY SHALL drive {cut_a,cut_b,cut_c}=vec and load the settle counter with SETTLE_CYCLES; next state SETTLE.
REQ-016 SETTLE SHALL hold the vector and decrement; at counter 1 go to CAPTURE (exactly SETTLE_CYCLES cycles in SETTLE).
REQ-017 CAPTURE SHALL compare CUT responses against golden values E=A&B, F=A|C, G=~C, H=A&B&C for the current vector.
REQ-018 On any bit mismatch in CAPTURE, mismatch_cnt SHALL increment by 1, at most once per vector.
REQ-019 CAPTURE: if vec==7 go to DONE, else increment vec and go to APPLY; vec SHALL not wrap within a scan.
REQ-020 DONE SHALL assert done for exactly one cycle, update trojan_flag, and return to IDLE.
REQ-021 busy SHALL be high in APPLY, SETTLE, CAPTURE, DONE, and low in IDLE.
REQ-022 start SHALL be ignored while busy; start in the same cycle as the DONE->IDLE transition SHALL be ignored.
REQ-023 Scan latency from start to done SHALL be 8*(SETTLE_CYCLES+2)+1 cycles.
REQ-024 mismatch_cnt, trojan_flag, fail_vec, fail_mask SHALL hold their values in IDLE until the next accepted start.
REQ-025 cut_a/b/c SHALL be 0 in IDLE.

Reset
REQ-026 rst SHALL force IDLE immediately, including mid-scan, with no done pulse.
REQ-027 Reset values: cut_a/b/c=0, busy=0, done=0, mismatch_cnt=0, trojan_flag=0, fail_vec=0, fail_mask=0.

Configuration
REQ-028 TROJAN_SCAN_LOG_EN defined: fail_vec and fail_mask SHALL capture the vector index and mismatch bits of the first failing vector per scan, cleared on start.
REQ-029 TROJAN_SCAN_LOG_EN undefined: fail_vec and fail_mask SHALL be constant 0, and no log registers SHALL be built.

Structure
REQ-030 Shared package trojan_scan_pkg SHALL hold the FSM state enum, the NUM_VECTORS=8 constant, and a golden-response function that maps a 3-bit vector to 4 bits {E,F,G,H}.
REQ-031 The block SHALL be a single module; the settle counter MAY be a sub-module named scan_settle_cnt.

Verification
REQ-032 Clean CUT model, start -> done after 33 cycles (SETTLE_CYCLES=2), mismatch_cnt=0, trojan_flag=0.
REQ-033 Trojan CUT model H=A&B&C | ~(A&~C), start -> mismatch_cnt=5 (vectors 0,1,2,3,5), trojan_flag=1; with LOG_EN, fail_vec=0 and fail_mask=4'b0001.
REQ-034 CUT with E stuck-at-0 -> mismatch_cnt=2 (vectors 6,7); with LOG_EN, fail_vec=6 and fail_mask=4'b1000.
REQ-035 start pulsed again at cycle 10 of a scan -> ignored, single done, counts unchanged from REQ-032.
REQ-036 rst asserted during vector 4 SETTLE -> outputs at reset values same cycle, no done; a new start then gives a full correct scan.

Source files
------------

// File: rtl/trojan_scan_pkg.sv
// Shared types and helpers for the trojan scan controller: FSM state
// encoding, vector count and the golden CUT response function.
package trojan_scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    CAPTURE,
    DONE
  } scan_state_t;

  localparam int NUM_VECTORS = 8;

  // Expected {E,F,G,H} for a vector laid out as {A,B,C}.
  function automatic logic [3:0] golden_resp(input logic [2:0] vec);
    logic a, b, c;
    a = vec[2];
    b = vec[1];
    c = vec[0];
    return {a & b, a | c, ~c, a & b & c};
  endfunction

endpackage

// File: rtl/trojan_scan_ctrl_settle.sv
// Down-counter that times the settle window between applying a vector
// and capturing the CUT response.
module scan_settle_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] value,
  output logic [3:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 4'd0;
    end else if (load) begin
      count <= value;
    end else if (dec && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

endmodule

// File: rtl/trojan_scan_ctrl.sv
// Walks all eight {A,B,C} vectors through the CUT and counts responses that
// differ from golden. Define TROJAN_SCAN_LOG_EN to record the first failure.
module trojan_scan_ctrl
  import trojan_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       cut_a,
  output logic       cut_b,
  output logic       cut_c,
  input  logic       cut_e,
  input  logic       cut_f,
  input  logic       cut_g,
  input  logic       cut_h,
  output logic       busy,
  output logic       done,
  output logic [3:0] mismatch_cnt,
  output logic       trojan_flag,
  output logic [2:0] fail_vec,
  output logic [3:0] fail_mask
);

  localparam logic [2:0] LAST_VEC = 3'(NUM_VECTORS - 1);

  scan_state_t state, state_next;
  logic [2:0]  vec;
  logic [3:0]  settle_cnt;
  logic [3:0]  diff;
  logic        capture_fail;
  logic        scan_go;

  assign scan_go      = (state == IDLE) && start;
  assign diff         = {cut_e, cut_f, cut_g, cut_h} ^ golden_resp(vec);
  assign capture_fail = (state == CAPTURE) && (diff != 4'd0);

  scan_settle_cnt u_settle (
    .clk   (clk),
    .rst   (rst),
    .load  (state == APPLY),
    .dec   (state == SETTLE),
    .value (4'(SETTLE_CYCLES)),
    .count (settle_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = APPLY;
      APPLY:   state_next = SETTLE;
      SETTLE:  if (settle_cnt <= 4'd1) state_next = CAPTURE;
      CAPTURE: state_next = (vec == LAST_VEC) ? DONE : APPLY;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The trojan flag is only refreshed once the whole scan has been counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec          <= 3'd0;
      mismatch_cnt <= 4'd0;
      trojan_flag  <= 1'b0;
    end else if (scan_go) begin
      vec          <= 3'd0;
      mismatch_cnt <= 4'd0;
      trojan_flag  <= 1'b0;
    end else if (state == CAPTURE) begin
      if (capture_fail) mismatch_cnt <= mismatch_cnt + 4'd1;
      if (vec != LAST_VEC) vec <= vec + 3'd1;
    end else if (state == DONE) begin
      trojan_flag <= (mismatch_cnt != 4'd0);
    end
  end

`ifdef TROJAN_SCAN_LOG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_vec  <= 3'd0;
      fail_mask <= 4'd0;
    end else if (scan_go) begin
      fail_vec  <= 3'd0;
      fail_mask <= 4'd0;
    end else if (capture_fail && mismatch_cnt == 4'd0) begin
      fail_vec  <= vec;
      fail_mask <= diff;
    end
  end
`else
  assign fail_vec  = 3'd0;
  assign fail_mask = 4'd0;
`endif

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign {cut_a, cut_b, cut_c} =
    (state == APPLY || state == SETTLE || state == CAPTURE) ? vec : 3'd0;

endmodule
